i2s_rx_core: RTL
================

Name: i2s_rx_core

Overview:
- I2S slave receiver, the receive-side counterpart of the I2S transmit core.
- Takes external i2s_sck_i and i2s_ws_i, which it oversamples on the system clock, and deserialises i2s_sd_i into one word per channel slot.
- Delivers each word with its channel tag on a valid/ready stream to the register/FIFO layer of the I2S peripheral.

Parameters:
- DATA_WIDTH, 32: width of rx_data_o. Must be ≥ 32.
- SYNC_STAGES, 2: number of synchroniser flops on sck, ws and sd.

Ports:
- clk_i, input, 1: system clock.
- rst_n_i, input, 1: synchronous active-low reset.
- en_i, input, 1: receiver enable. Low acts as a soft synchronous clear.
- lsb_i, input, 1: 0 = MSB received first; 1 = LSB received first.
- fmt_i, input, 2: 00 Philips (1-bit delay); 01 left-justified; 10/11 reserved, treated as Philips.
- chl_i, input, 2: word width W. 00 = 8, 01 = 16, 10 = 24, 11 = 32 bits.
- busy_o, output, 1: high while a word is being shifted in.
- chd_o, output, 1: channel of the word in rx_data_o. 0 = left (ws = 0), 1 = right.
- ovf_o, output, 1: sticky overflow flag.
- rx_valid_o, output, 1: output word valid.
- rx_ready_i, input, 1: consumer ready.
- rx_data_o, output, DATA_WIDTH: received word.
- i2s_sck_i, input, 1: I2S bit clock (asynchronous).
- i2s_ws_i, input, 1: I2S word select (asynchronous).
- i2s_sd_i, input, 1: I2S serial data (asynchronous).

Behaviour:
- Clocking and reset
  - Single clock. Reset is synchronous and active-low.
  - While rst_n_i = 0 the block is held in IDLE, and rx_valid_o, rx_data_o, chd_o, ovf_o and busy_o are all 0.
- Input sampling
  - sck, ws and sd each pass through SYNC_STAGES flops.
  - sck_re is a one-clk pulse on each synchronised sck rising edge. All sampling happens only in sck_re cycles.
  - Required timing: sck high time and low time are each ≥ SYNC_STAGES+2 clk periods.
- Boundary detection
  - On each sck_re, sample ws_s and sd_s together.
  - A boundary is an sck_re where the sampled ws_s differs from the ws sampled at the previous sck_re.
- FSM states: IDLE, WAIT, SHIFT.
  - IDLE: entered whenever en_i = 0. Clears the bit counter, the shift register, rx_valid_o and ovf_o. Moves to WAIT when en_i = 1.
  - WAIT: discards bits until the first boundary, then moves to SHIFT. The partial first slot is never delivered.
  - SHIFT: busy_o = 1. The bit counter (0..32) increments on each captured bit. Bits beyond W are ignored.
- Bit placement
  - Each captured bit goes to position W-1-cnt when lsb_i = 0, or position cnt when lsb_i = 1.
  - Position is within a W-bit word.
- Word commit at each boundary in SHIFT
  - Philips: the sd sampled at the boundary edge belongs to the outgoing word, if cnt < W. The new word's bit 0 arrives at the next sck_re.
  - Left-justified: the boundary-edge bit is bit 0 of the new word.
  - The committed word's channel is the ws value of its slot.
  - A short slot (fewer than W bits) commits with the missing bits 0.
  - The counter resets for the new slot.
- Output register
  - Loaded 1 clk after the commit sck_re cycle.
  - rx_data_o = word in bits [DATA_WIDTH-1 : DATA_WIDTH-W], with lower bits 0 (MSB-aligned, matching the transmit side).
  - chd_o is loaded together with rx_data_o.
- Handshake and overflow
  - rx_valid_o stays high until rx_valid_o & rx_ready_i.
  - If a commit occurs in the same cycle as an accept, the new word loads and rx_valid_o stays 1.
  - If a commit occurs while rx_valid_o = 1 and rx_ready_i = 0, the new word is dropped, the held word is unchanged, and ovf_o is set.
  - ovf_o is cleared only by reset or en_i = 0.
- Mid-operation changes
  - en_i deasserted mid-word aborts immediately. Any pending output word is discarded.
  - chl_i, fmt_i and lsb_i are only guaranteed stable-safe while en_i = 0. Behaviour on a change while enabled is unspecified but must not lock up; the next boundary resynchronises.

Optional Feature:
- Macro: I2S_RX_SIGN_EXT_EN.
- Defined: rx_data_o carries the W-bit word right-aligned in [W-1:0], sign-extended from bit W-1 up to DATA_WIDTH.
- Undefined: MSB-aligned and zero-padded, as described in Behaviour.

Test Plan:
- Philips, W = 16, lsb_i = 0, left slot 0xA5C3 then right slot 0x1234 (32 sck per frame) → words {0xA5C30000, chd 0} then {0x12340000, chd 1}. The first partial slot after enable is not delivered.
- Left-justified, W = 8, lsb_i = 1, send bits LSB-first for 0x81 → rx_data_o = 0x81000000. With I2S_RX_SIGN_EXT_EN → 0xFFFFFF81.
- Philips, W = 24, short slot of only 20 bits carrying 0xFFFFF → 0xFFFFF0 in [31:8], i.e. 0xFFFFF000.
- Backpressure: rx_ready_i = 0 across three commits → first word held unchanged, ovf_o = 1 after the second commit. en_i low for 1 clk → ovf_o = 0, rx_valid_o = 0.
- Accept coincident with commit (rx_ready_i = 1 every cycle) → no ovf_o, every word delivered in order. rx_valid_o pulses 1 clk per word.
- en_i dropped at bit 10 of a W = 32 slot, then re-enabled → no word from the aborted slot. Reception restarts at the next boundary with correct data.

Source files
------------

// File: rtl/i2s_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_core
// Brief    : I2S slave receiver. Oversamples sck/ws/sd, deserialises one word
//            per channel slot, delivers it on a valid/ready stream.
//            Optional I2S_RX_SIGN_EXT_EN: right-aligned, sign-extended output.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_core #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  lsb_i,
    input  logic [1:0]            fmt_i,
    input  logic [1:0]            chl_i,
    output logic                  busy_o,
    output logic                  chd_o,
    output logic                  ovf_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_ws_sync, r_sd_sync;
    logic [SYNC_STAGES:0]   w_sck_chain, w_ws_chain, w_sd_chain;
    logic                   w_sck_s, w_ws_s, w_sd_s;
    logic                   r_sck_prev, r_ws_prev, r_ws_seen;
    logic                   w_sck_re, w_boundary;

    logic [1:0]             r_state;
    logic [5:0]             r_cnt;
    logic [31:0]            r_shreg;
    logic                   r_commit;
    logic [DATA_WIDTH-1:0]  r_cdata;
    logic                   r_cch;

    logic [5:0]             w_width;
    logic [4:0]             w_wm1;
    logic                   w_lj, w_in_range;
    logic [4:0]             w_pos, w_pos0;
    logic [31:0]            w_cap, w_new_first, w_commit_word, w_aligned;
    logic [DATA_WIDTH-1:0]  w_fmt;

    logic                   r_rx_valid, r_chd, r_ovf;
    logic [DATA_WIDTH-1:0]  r_rx_data;

    assign w_sck_chain = {r_sck_sync, i2s_sck_i};
    assign w_ws_chain  = {r_ws_sync, i2s_ws_i};
    assign w_sd_chain  = {r_sd_sync, i2s_sd_i};
    assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
    assign w_ws_s      = r_ws_sync[SYNC_STAGES-1];
    assign w_sd_s      = r_sd_sync[SYNC_STAGES-1];

    assign w_sck_re   = w_sck_s & ~r_sck_prev;
    // ws history is only trusted once a post-enable edge has been seen
    assign w_boundary = w_sck_re & r_ws_seen & (w_ws_s ^ r_ws_prev);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_sd_sync  <= '0;
            r_sck_prev <= 1'b0;
            r_ws_prev  <= 1'b0;
            r_ws_seen  <= 1'b0;
        end else begin
            r_sck_sync <= w_sck_chain[SYNC_STAGES-1:0];
            r_ws_sync  <= w_ws_chain[SYNC_STAGES-1:0];
            r_sd_sync  <= w_sd_chain[SYNC_STAGES-1:0];
            r_sck_prev <= w_sck_s;
            if (w_sck_re) r_ws_prev <= w_ws_s;
            if (!en_i)         r_ws_seen <= 1'b0;
            else if (w_sck_re) r_ws_seen <= 1'b1;
        end
    end

    always_comb begin
        w_width = 6'd32;
        w_wm1   = 5'd31;
        case (chl_i)
            2'b00:   begin w_width = 6'd8;  w_wm1 = 5'd7;  end
            2'b01:   begin w_width = 6'd16; w_wm1 = 5'd15; end
            2'b10:   begin w_width = 6'd24; w_wm1 = 5'd23; end
            default: begin w_width = 6'd32; w_wm1 = 5'd31; end
        endcase
    end

    assign w_lj          = (fmt_i == 2'b01);
    assign w_in_range    = (r_cnt < w_width);
    assign w_pos         = lsb_i ? r_cnt[4:0] : (w_wm1 - r_cnt[4:0]);
    assign w_pos0        = lsb_i ? 5'd0 : w_wm1;
    assign w_cap         = {31'd0, w_sd_s & w_in_range} << w_pos;
    assign w_new_first   = {31'd0, w_sd_s} << w_pos0;
    // Philips: the boundary-edge bit still belongs to the outgoing word
    assign w_commit_word = w_lj ? r_shreg : (r_shreg | w_cap);
    assign w_aligned     = w_commit_word << (6'd32 - w_width);

`ifdef I2S_RX_SIGN_EXT_EN
    logic signed [31:0] w_sext;
    assign w_sext = $signed(w_aligned) >>> (6'd32 - w_width);
    assign w_fmt  = DATA_WIDTH'(w_sext);
`else
    assign w_fmt  = DATA_WIDTH'(w_aligned) << (DATA_WIDTH - 32);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= c_st_idle;
            r_cnt    <= 6'd0;
            r_shreg  <= 32'd0;
            r_commit <= 1'b0;
            r_cdata  <= '0;
            r_cch    <= 1'b0;
        end else if (!en_i) begin
            r_state  <= c_st_idle;
            r_cnt    <= 6'd0;
            r_shreg  <= 32'd0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            case (r_state)
                c_st_idle: r_state <= c_st_wait;
                c_st_wait: begin
                    if (w_boundary) begin
                        r_state <= c_st_shift;
                        r_cnt   <= w_lj ? 6'd1 : 6'd0;
                        r_shreg <= w_lj ? w_new_first : 32'd0;
                    end
                end
                c_st_shift: begin
                    if (w_boundary) begin
                        r_commit <= 1'b1;
                        r_cdata  <= w_fmt;
                        r_cch    <= r_ws_prev;
                        r_cnt    <= w_lj ? 6'd1 : 6'd0;
                        r_shreg  <= w_lj ? w_new_first : 32'd0;
                    end else if (w_sck_re) begin
                        r_shreg <= r_shreg | w_cap;
                        if (r_cnt != 6'd32) r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !en_i) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_chd      <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (r_commit) begin
            if (!r_rx_valid || rx_ready_i) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_cdata;
                r_chd      <= r_cch;
            end else begin
                r_ovf <= 1'b1;
            end
        end else if (rx_ready_i) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign busy_o     = (r_state == c_st_shift);
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
    assign chd_o      = r_chd;
    assign ovf_o      = r_ovf;

endmodule
`default_nettype wire
